error_comp_accum: RTL and testbench

//  Parametrised, sequential successor to the fixed 7-term AM2 error-compensation tree.

---
 rtl/error_comp_accum_if.sv | 40 ++++
 rtl/error_comp_accum.sv | 161 ++++++++++++++++
 tb/tb_error_comp_accum.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/error_comp_accum_if.sv
// Stream bundle for the error-compensation accumulator: term input stream,
// result output stream and the frame-in-progress indicator.
interface error_comp_accum_if #(
    parameter int W  = 9,
    parameter int OW = 24
);
    logic          mode;
    logic          term_valid;
    logic          term_ready;
    logic [W-1:0]  term_data;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic          out_mode;
    logic          busy;

    modport master (
        output mode,
        output term_valid,
        output term_data,
        output out_ready,
        input  term_ready,
        input  out_valid,
        input  out_data,
        input  out_mode,
        input  busy
    );

    modport slave (
        input  mode,
        input  term_valid,
        input  term_data,
        input  out_ready,
        output term_ready,
        output out_valid,
        output out_data,
        output out_mode,
        output busy
    );
endinterface

// File: rtl/error_comp_accum.sv
// Serial weighted accumulator for N error terms; produces one compensation word per
// frame, either exactly or with OR-merged low bits and no carry out of them.
module error_comp_accum #(
    parameter int W          = 9,
    parameter int N          = 7,
    parameter int SHIFT      = 2,
    parameter int APPROX_LSB = 4
) (
    input  logic               clk,
    input  logic               rst,
    error_comp_accum_if.slave  bus
);
    localparam int OW = W + SHIFT * (N - 1) + $clog2(N);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
    localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};
    localparam logic [OW-1:0] ZERO_ACC = {OW{1'b0}};

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic          term_ready_r;
    logic          out_valid_r;
    logic [CW-1:0] cnt_r;
    logic [OW-1:0] acc_r;
    logic          mode_r;
    logic          busy_r;
    logic [OW-1:0] out_data_r;
    logic          out_mode_r;

    logic          xfer_s;
    logic          take_s;
    logic          first_s;
    logic          mode_eff_s;
    logic [OW-1:0] acc_base_s;
    logic [OW-1:0] term_sh_s;
    logic [OW-1:0] sum_exact_s;
    logic [OW-1:0] sum_approx_s;
    logic [OW-1:0] acc_nxt_s;

    // Zero-extend a term to the result width and apply its positional weight.
    function automatic logic [OW-1:0] shift_term(input logic [W-1:0] d, input logic [CW-1:0] k);
        logic [OW-1:0] z;
        z = {{(OW - W){1'b0}}, d};
        return z << (SHIFT * int'(k));
    endfunction

    // Next-state and handshake decode.
    always_comb begin
        state_nxt_s = state_r;
        xfer_s      = 1'b0;
        take_s      = 1'b0;
        case (state_r)
            ST_ACC: begin
                xfer_s = bus.term_valid;
                if (bus.term_valid && (cnt_r == LAST_CNT)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_ACC;
                end
            end
            ST_DONE: begin
                take_s = bus.out_ready;
                if (bus.out_ready) begin
                    state_nxt_s = ST_ACC;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_ACC;
            end
        endcase
    end

    // Term weighting and the two reduction flavours; the first term of a frame
    // starts from zero and decides the mode for the whole frame.
    always_comb begin
        first_s    = (cnt_r == ZERO_CNT);
        mode_eff_s = mode_r;
        acc_base_s = acc_r;
        if (first_s) begin
            mode_eff_s = bus.mode;
            acc_base_s = ZERO_ACC;
        end else begin
            mode_eff_s = mode_r;
            acc_base_s = acc_r;
        end
        term_sh_s   = shift_term(bus.term_data, cnt_r);
        sum_exact_s = acc_base_s + term_sh_s;
        if (mode_eff_s) begin
            acc_nxt_s = sum_approx_s;
        end else begin
            acc_nxt_s = sum_exact_s;
        end
    end

    // Approximate sum: low bits merged by OR, upper field added with no carry-in.
    generate
        if (APPROX_LSB == 0) begin : g_no_approx
            assign sum_approx_s = sum_exact_s;
        end else begin : g_approx
            assign sum_approx_s = {acc_base_s[OW-1:APPROX_LSB] + term_sh_s[OW-1:APPROX_LSB],
                                   acc_base_s[APPROX_LSB-1:0] | term_sh_s[APPROX_LSB-1:0]};
        end
    endgenerate

    // State register with registered stream flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_ACC;
            term_ready_r <= 1'b1;
            out_valid_r  <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            term_ready_r <= (state_nxt_s == ST_ACC);
            out_valid_r  <= (state_nxt_s == ST_DONE);
        end
    end

    // Accumulator, term counter, frame mode and result holding registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r      <= ZERO_ACC;
            cnt_r      <= ZERO_CNT;
            mode_r     <= 1'b0;
            busy_r     <= 1'b0;
            out_data_r <= ZERO_ACC;
            out_mode_r <= 1'b0;
        end else if (xfer_s) begin
            acc_r  <= acc_nxt_s;
            mode_r <= mode_eff_s;
            busy_r <= 1'b1;
            if (cnt_r == LAST_CNT) begin
                // Counter parks at N-1 until the result is taken.
                cnt_r      <= cnt_r;
                out_data_r <= acc_nxt_s;
                out_mode_r <= mode_eff_s;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end else if (take_s) begin
            acc_r  <= ZERO_ACC;
            cnt_r  <= ZERO_CNT;
            busy_r <= 1'b0;
        end else begin
            acc_r <= acc_r;
            cnt_r <= cnt_r;
        end
    end

    assign bus.term_ready = term_ready_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_data   = out_data_r;
    assign bus.out_mode   = out_mode_r;
    assign bus.busy       = busy_r;
endmodule

// File: tb/tb_error_comp_accum.sv
// Self-checking bench for error_comp_accum: directed scenarios plus randomized
// frames checked against an arithmetic reference model.
module tb_error_comp_accum;
    localparam int W  = 9;
    localparam int N  = 7;
    localparam int SH = 2;
    localparam int AL = 4;
    localparam int OW = 24;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;
    logic [W-1:0] terms [N];

    always #5 clk = ~clk;

    error_comp_accum_if #(.W(W), .OW(OW)) bus ();

    error_comp_accum #(.W(W), .N(N), .SHIFT(SH), .APPROX_LSB(AL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference: exact = sum of e_k * 2^(SH*k); approx = upper fields summed, low bits ORed.
    function automatic logic [OW-1:0] model(input logic m);
        longint exact, hi, lo, v;
        exact = 0; hi = 0; lo = 0;
        for (int k = 0; k < N; k++) begin
            v = longint'(terms[k]) << (SH * k);
            exact += v;
            hi += v >> AL;
            lo |= v & ((longint'(1) << AL) - 1);
        end
        if (m) return OW'((hi << AL) | lo);
        return OW'(exact);
    endfunction

    task automatic send_term(input logic [W-1:0] d, input logic m);
        int guard;
        bus.term_valid = 1'b1;
        bus.term_data  = d;
        bus.mode       = m;
        guard = 0;
        while (bus.term_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            vectors++; miscompares++;
            $display("FAIL send_term_timeout: term_ready=%b required 1", bus.term_ready);
        end
        @(negedge clk);
        bus.term_valid = 1'b0;
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic wait_valid();
        int guard;
        guard = 0;
        while (bus.out_valid !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            vectors++; miscompares++;
            $display("FAIL wait_valid_timeout: out_valid=%b required 1", bus.out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.term_valid = 1'b0; bus.term_data = '0; bus.mode = 1'b0; bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        vectors++; if (bus.term_ready !== 1'b1) begin miscompares++; $display("FAIL reset_term_ready: got %b want 1", bus.term_ready); end
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        vectors++; if (bus.out_data !== 24'h0) begin miscompares++; $display("FAIL reset_out_data: got %h want 000000", bus.out_data); end
        vectors++; if (bus.out_mode !== 1'b0) begin miscompares++; $display("FAIL reset_out_mode: got %b want 0", bus.out_mode); end
    endtask

    task automatic test_exact();
        for (int k = 0; k < N - 1; k++) send_term(9'h1FF, 1'b0);
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL exact_early_valid: got %b want 0", bus.out_valid); end
        vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL exact_busy: got %b want 1", bus.busy); end
        send_term(9'h1FF, 1'b0);
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL exact_latency: out_valid got %b want 1", bus.out_valid); end
        vectors++; if (bus.out_data !== 24'h2A94AB) begin miscompares++; $display("FAIL exact_data: got %h want 2a94ab", bus.out_data); end
        vectors++; if (bus.out_mode !== 1'b0) begin miscompares++; $display("FAIL exact_mode: got %b want 0", bus.out_mode); end
        consume();
        vectors++; if (bus.out_valid !== 1'b0 || bus.term_ready !== 1'b1 || bus.busy !== 1'b0) begin
            miscompares++; $display("FAIL exact_return: valid/ready/busy got %b%b%b want 010", bus.out_valid, bus.term_ready, bus.busy);
        end
    endtask

    task automatic test_approx();
        logic [W-1:0] st [N];
        st[0] = 9'h00F; st[1] = 9'h003;
        for (int k = 2; k < N; k++) st[k] = 9'h000;
        for (int k = 0; k < N; k++) send_term(st[k], 1'b1);
        wait_valid();
        vectors++; if (bus.out_data !== 24'h00000F) begin miscompares++; $display("FAIL approx_data: got %h want 00000f", bus.out_data); end
        vectors++; if (bus.out_mode !== 1'b1) begin miscompares++; $display("FAIL approx_mode: got %b want 1", bus.out_mode); end
        consume();
        for (int k = 0; k < N; k++) send_term(st[k], 1'b0);
        wait_valid();
        vectors++; if (bus.out_data !== 24'h00001B) begin miscompares++; $display("FAIL approx_as_exact_data: got %h want 00001b", bus.out_data); end
        consume();
    endtask

    task automatic test_backpressure();
        logic [OW-1:0] exp;
        for (int k = 0; k < N; k++) terms[k] = W'($urandom);
        exp = model(1'b0);
        for (int k = 0; k < N; k++) send_term(terms[k], 1'b0);
        bus.term_valid = 1'b1;
        bus.term_data  = W'($urandom);
        for (int c = 0; c < 5; c++) begin
            vectors++; if (bus.term_ready !== 1'b0) begin miscompares++; $display("FAIL bp_term_ready: cycle %0d got %b want 0", c, bus.term_ready); end
            vectors++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp) begin
                miscompares++; $display("FAIL bp_hold: cycle %0d valid %b data %h want 1 %h", c, bus.out_valid, bus.out_data, exp);
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        vectors++; if (bus.term_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            miscompares++; $display("FAIL bp_release: ready/valid/busy got %b%b%b want 100", bus.term_ready, bus.out_valid, bus.busy);
        end
        vectors++; if (bus.out_data !== exp) begin miscompares++; $display("FAIL bp_data_held: got %h want %h", bus.out_data, exp); end
        bus.term_valid = 1'b0;
        for (int k = 0; k < N; k++) terms[k] = W'($urandom);
        exp = model(1'b0);
        for (int k = 0; k < N; k++) send_term(terms[k], 1'b0);
        vectors++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp) begin
            miscompares++; $display("FAIL bp_next_frame: valid %b data %h want 1 %h", bus.out_valid, bus.out_data, exp);
        end
        consume();
    endtask

    task automatic test_reset_midframe();
        for (int k = 0; k < 3; k++) send_term(W'($urandom), 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.term_ready !== 1'b1) begin
            miscompares++; $display("FAIL midreset_state: valid/busy/ready got %b%b%b want 001", bus.out_valid, bus.busy, bus.term_ready);
        end
        for (int k = 0; k < N; k++) send_term(9'h001, 1'b0);
        vectors++; if (bus.out_data !== 24'h001555 || bus.out_valid !== 1'b1) begin
            miscompares++; $display("FAIL midreset_data: got %h valid %b want 001555 1", bus.out_data, bus.out_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++; if (bus.out_valid !== 1'b0 || bus.out_data !== 24'h0) begin
            miscompares++; $display("FAIL outreset: valid %b data %h want 0 000000", bus.out_valid, bus.out_data);
        end
    endtask

    task automatic test_gapped();
        for (int k = 0; k < N; k++) begin
            send_term(9'h1FF, 1'b0);
            if (k < N - 1) begin
                vectors++; if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
                    miscompares++; $display("FAIL gap_busy: term %0d busy %b valid %b want 1 0", k, bus.busy, bus.out_valid);
                end
            end
            @(negedge clk);
        end
        vectors++; if (bus.out_valid !== 1'b1 || bus.out_data !== 24'h2A94AB) begin
            miscompares++; $display("FAIL gap_data: valid %b data %h want 1 2a94ab", bus.out_valid, bus.out_data);
        end
        consume();
    endtask

    task automatic test_mode_latch();
        send_term(9'h00F, 1'b1);
        send_term(9'h003, 1'b0);
        for (int k = 2; k < N; k++) send_term(9'h000, 1'b0);
        wait_valid();
        vectors++; if (bus.out_data !== 24'h00000F) begin miscompares++; $display("FAIL latch_data: got %h want 00000f", bus.out_data); end
        vectors++; if (bus.out_mode !== 1'b1) begin miscompares++; $display("FAIL latch_mode: got %b want 1", bus.out_mode); end
        consume();
    endtask

    task automatic test_random();
        logic [OW-1:0] exp;
        logic          mf;
        for (int f = 0; f < 30; f++) begin
            for (int k = 0; k < N; k++) terms[k] = W'($urandom);
            mf  = 1'($urandom);
            exp = model(mf);
            for (int k = 0; k < N; k++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send_term(terms[k], (k == 0) ? mf : 1'($urandom));
            end
            wait_valid();
            vectors++; if (bus.out_data !== exp || bus.out_mode !== mf) begin
                miscompares++; $display("FAIL rand_frame %0d: data %h mode %b want %h %b", f, bus.out_data, bus.out_mode, exp, mf);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            vectors++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp) begin
                miscompares++; $display("FAIL rand_hold %0d: valid %b data %h want 1 %h", f, bus.out_valid, bus.out_data, exp);
            end
            consume();
        end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_approx();
        test_backpressure();
        test_reset_midframe();
        test_gapped();
        test_mode_latch();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1);
    end
endmodule
